// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces horizontal/vertical sync, display enable and blanking from generic
// H/V timing. Also produces scaled pixel positions for the mode controllers
// and a scan-line interrupt. Everything advances only on pix_ce.
// hsync_o/vsync_o/de_o are delayed through a short pipeline. This lines them
// up with the pixel-fetch latency of the screen RAM and character ROM path.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_DLY   = 2,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic [1:0]    scale,
    input  logic [CW-1:0] irq_line,
    input  logic          irq_en,
    input  logic          irq_ack,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          vblank_o,
    output logic          line_start,
    output logic          frame_start,
    output logic          irq
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Raster counters and stage-0 registers.
    logic [CW-1:0] h_reg;
    logic [CW-1:0] v_reg;
    logic [1:0]    scale_reg;
    logic [CW-1:0] posx_reg;
    logic [CW-1:0] posy_reg;
    logic          vblank_reg;
    logic          line_start_reg;
    logic          frame_start_reg;
    logic          irq_reg;
    // Stage-0 sync bundle, active-high internally: {de, hsync, vsync}.
    logic [2:0]    sync0_reg;
    logic [2:0]    sync_out;

    // Combinational next values, computed from the raster position before it advances.
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_last;
    logic          v_last;
    logic          h_vis;
    logic          v_vis;
    logic          hs_next;
    logic          vs_next;
    logic          line_c;
    logic          frame_c;
    logic [1:0]    scale_sat;
    logic [1:0]    scale_use;
    logic [CW-1:0] posx_next;
    logic [CW-1:0] posy_next;
    logic          irq_hit;

    // Next-position and stage-0 decode from the current (h,v).
    always_comb begin
        h_last    = (int'(h_reg) == H_TOTAL - 1);
        v_last    = (int'(v_reg) == V_TOTAL - 1);
        h_next    = h_last ? '0 : h_reg + CW'(1);
        v_next    = v_reg;
        if (h_last) begin
            v_next = v_last ? '0 : v_reg + CW'(1);
        end
        h_vis     = (int'(h_reg) < H_ACTIVE);
        v_vis     = (int'(v_reg) < V_ACTIVE);
        hs_next   = (int'(h_reg) >= HS_START) && (int'(h_reg) < HS_END);
        vs_next   = (int'(v_reg) >= VS_START) && (int'(v_reg) < VS_END);
        line_c    = (h_reg == '0);
        frame_c   = line_c && (v_reg == '0);
        // scale=3 saturates to the 4x divider.
        scale_sat = (scale == 2'd3) ? 2'd2 : scale;
        // At the frame-start edge the newly latched divider already applies,
        // so a whole frame is always rendered with one scale (no tearing).
        scale_use = frame_c ? scale_sat : scale_reg;
        posx_next = h_vis ? (h_reg >> scale_use) : '0;
        posy_next = v_vis ? (v_reg >> scale_use) : '0;
        // irq_line values >= V_TOTAL can never match v, so they never fire.
        irq_hit   = line_c && irq_en && (irq_line == v_reg);
    end

    // Raster counters, stage-0 outputs and start pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg           <= '0;
            v_reg           <= '0;
            scale_reg       <= 2'd0;
            posx_reg        <= '0;
            posy_reg        <= '0;
            vblank_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            sync0_reg       <= 3'b000;
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            if (pix_ce) begin
                h_reg           <= h_next;
                v_reg           <= v_next;
                posx_reg        <= posx_next;
                posy_reg        <= posy_next;
                vblank_reg      <= ~v_vis;
                line_start_reg  <= line_c;
                frame_start_reg <= frame_c;
                sync0_reg       <= {h_vis && v_vis, hs_next, vs_next};
                if (frame_c) begin
                    scale_reg <= scale_sat;
                end
            end
        end
    end

    // Scan-line interrupt: a set on the matching line start beats a simultaneous ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else if (pix_ce && irq_hit) begin
            irq_reg <= 1'b1;
        end else if (irq_ack) begin
            irq_reg <= 1'b0;
        end
    end

    // Sync/DE delay line that matches the fetch latency of the mode controllers.
    generate
        if (PIPE_DLY == 0) begin : g_no_pipe
            assign sync_out = sync0_reg;
        end else begin : g_pipe
            logic [2:0] pipe_reg [PIPE_DLY];

            // Shift the sync bundle one stage per pixel enable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        pipe_reg[i] <= 3'b000;
                    end
                end else if (pix_ce) begin
                    pipe_reg[0] <= sync0_reg;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        pipe_reg[i] <= pipe_reg[i-1];
                    end
                end
            end

            assign sync_out = pipe_reg[PIPE_DLY-1];
        end
    endgenerate

    // Apply the configured pin polarity to the internal active-high syncs.
    assign de_o        = sync_out[2];
    assign hsync_o     = sync_out[1] ? H_SYNC_POL : ~H_SYNC_POL;
    assign vsync_o     = sync_out[0] ? V_SYNC_POL : ~V_SYNC_POL;
    assign posx        = posx_reg;
    assign posy        = posy_reg;
    assign vblank_o    = vblank_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with small timing: H 8/2/3/3, V 4/1/2/1.
// Stimulus pushes the expected output record for every clock edge. It also
// pushes hand-computed spot values tied to specific edges. A negedge monitor
// pops the records and compares them against the DUT.
module tb_vga_timing_gen;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_ce;
    logic [1:0]    scale;
    logic [CW-1:0] irq_line;
    logic          irq_en;
    logic          irq_ack;
    logic [CW-1:0] posx;
    logic [CW-1:0] posy;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic          vblank_o;
    logic          line_start;
    logic          frame_start;
    logic          irq;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .PIPE_DLY(2), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_ce(pix_ce),
        .scale(scale),
        .irq_line(irq_line),
        .irq_en(irq_en),
        .irq_ack(irq_ack),
        .posx(posx),
        .posy(posy),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .de_o(de_o),
        .vblank_o(vblank_o),
        .line_start(line_start),
        .frame_start(frame_start),
        .irq(irq)
    );

    typedef struct {
        int seq;
        int posx;
        int posy;
        bit hs;
        bit vs;
        bit de;
        bit vb;
        bit ls;
        bit fs;
        bit irq;
    } exp_t;

    typedef struct {
        int    seq;
        string sig;
        int    val;
    } spot_t;

    exp_t  exp_q[$];
    spot_t spot_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    seq_cnt  = 0;

    // Expected-state tracking: sampled raster position, latched scale, irq,
    // and the stage-0 plus two delay stages of {de, hs, vs} (active high).
    int     th = 0;
    int     tv = 0;
    int     tscale = 0;
    bit     tirq = 1'b0;
    bit [2:0] m_s0 = '0;
    bit [2:0] m_p0 = '0;
    bit [2:0] m_p1 = '0;
    exp_t   last;

    task automatic check(input string name, input int seq, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @seq %0d: got %0d, expected %0d", name, seq, act, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(input string s);
        case (s)
            "posx":        return 32'(posx);
            "posy":        return 32'(posy);
            "hsync_o":     return 32'(hsync_o);
            "vsync_o":     return 32'(vsync_o);
            "de_o":        return 32'(de_o);
            "vblank_o":    return 32'(vblank_o);
            "line_start":  return 32'(line_start);
            "frame_start": return 32'(frame_start);
            "irq":         return 32'(irq);
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Queue a hand-computed value for the rel-th edge from now.
    task automatic spot(input int rel, input string sig, input int val);
        spot_t sp;
        sp.seq = seq_cnt + rel;
        sp.sig = sig;
        sp.val = val;
        spot_q.push_back(sp);
    endtask

    // Number of edges (pix_ce=1 every clk) until the edge that samples (h,v).
    function automatic int edges_to(input int h, input int v);
        return ((v - tv) * 16 + (h - th) + 128) % 128 + 1;
    endfunction

    // One clock edge: compute the expected record for it and hand it to the monitor.
    task automatic tick();
        exp_t e;
        int   h;
        int   v;
        int   sat;
        bit [2:0] n_sync;
        @(posedge clk);
        seq_cnt++;
        e = last;
        if (rst) begin
            th = 0; tv = 0; tscale = 0; tirq = 1'b0;
            m_s0 = '0; m_p0 = '0; m_p1 = '0;
            e.posx = 0; e.posy = 0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
            e.vb = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
            if (pix_ce) begin
                h = th;
                v = tv;
                sat = (scale == 2'd3) ? 2 : int'(scale);
                if (h == 0 && v == 0) tscale = sat;
                n_sync = {(h < 8 && v < 4), (h >= 10 && h < 13), (v >= 5 && v < 7)};
                m_p1 = m_p0;
                m_p0 = m_s0;
                m_s0 = n_sync;
                e.de   = m_p1[2];
                e.hs   = !m_p1[1];
                e.vs   = !m_p1[0];
                e.vb   = (v >= 4);
                e.posx = (h < 8) ? (h >> tscale) : 0;
                e.posy = (v < 4) ? (v >> tscale) : 0;
                e.ls   = (h == 0);
                e.fs   = (h == 0 && v == 0);
                if (h == 0 && v == int'(irq_line) && irq_en) tirq = 1'b1;
                else if (irq_ack) tirq = 1'b0;
                th = (h == 15) ? 0 : h + 1;
                if (h == 15) tv = (v == 7) ? 0 : v + 1;
            end else if (irq_ack) begin
                tirq = 1'b0;
            end
        end
        e.irq = tirq;
        e.seq = seq_cnt;
        last = e;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance (pix_ce=1) until the next edge samples (h,v); bounded.
    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        while (!(th == h && tv == v) && n < 200) begin
            tick();
            n++;
        end
        check("run_until_reached", seq_cnt, 32'(th == h && tv == v), 32'd1);
    endtask

    // Monitor: one record per clock edge, compared on the falling edge.
    exp_t  me;
    spot_t ms;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("posx",        me.seq, 32'(posx),        32'(me.posx));
            check("posy",        me.seq, 32'(posy),        32'(me.posy));
            check("hsync_o",     me.seq, 32'(hsync_o),     32'(me.hs));
            check("vsync_o",     me.seq, 32'(vsync_o),     32'(me.vs));
            check("de_o",        me.seq, 32'(de_o),        32'(me.de));
            check("vblank_o",    me.seq, 32'(vblank_o),    32'(me.vb));
            check("line_start",  me.seq, 32'(line_start),  32'(me.ls));
            check("frame_start", me.seq, 32'(frame_start), 32'(me.fs));
            check("irq",         me.seq, 32'(irq),         32'(me.irq));
            for (int i = spot_q.size() - 1; i >= 0; i--) begin
                if (spot_q[i].seq == me.seq) begin
                    ms = spot_q[i];
                    $display("txn seq=%0d %s expect %0d got %0d", ms.seq, ms.sig, ms.val, get_sig(ms.sig));
                    check({"spot_", ms.sig}, ms.seq, get_sig(ms.sig), 32'(ms.val));
                    spot_q.delete(i);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        rst = 1'b1; pix_ce = 1'b0; scale = 2'd0;
        irq_line = '0; irq_en = 1'b0; irq_ack = 1'b0;
        last = '{default: 0};

        // Reset state.
        spot(1, "hsync_o", 1); spot(1, "vsync_o", 1); spot(1, "de_o", 0); spot(1, "irq", 0);
        run(2);
        rst = 1'b0;
        pix_ce = 1'b1;

        // Raster and vertical timing from the first edge after release.
        $display("txn raster/vertical timing");
        spot(1, "frame_start", 1);  spot(1, "line_start", 1);
        spot(2, "line_start", 0);   spot(2, "de_o", 0);
        spot(3, "de_o", 1);         spot(10, "de_o", 1);
        spot(11, "de_o", 0);        spot(12, "hsync_o", 1);
        spot(13, "hsync_o", 0);     spot(15, "hsync_o", 0);
        spot(16, "hsync_o", 1);     spot(20, "posy", 1);
        spot(64, "vblank_o", 0);    spot(65, "vblank_o", 1);
        spot(70, "posy", 0);        spot(82, "vsync_o", 1);
        spot(83, "vsync_o", 0);     spot(114, "vsync_o", 0);
        spot(115, "vsync_o", 1);    spot(128, "frame_start", 0);
        spot(128, "vblank_o", 1);   spot(129, "frame_start", 1);
        spot(129, "vblank_o", 0);
        run(150);

        // Scale change mid-frame takes effect only at the next frame start.
        $display("txn scale=1 mid-frame");
        scale = 2'd1;
        k  = edges_to(3, 2);
        k2 = edges_to(0, 0);
        spot(k, "posx", 3);
        spot(k2, "frame_start", 1);
        spot(k2 + 1, "posx", 0); spot(k2 + 2, "posx", 1);
        spot(k2 + 4, "posx", 2); spot(k2 + 7, "posx", 3);
        run(k2 + 8);
        $display("txn scale=3 mid-frame");
        scale = 2'd3;
        k  = edges_to(2, 1);
        k2 = edges_to(0, 0);
        spot(k, "posx", 1);
        spot(k2 + 3, "posx", 0); spot(k2 + 4, "posx", 1); spot(k2 + 7, "posx", 1);
        run(k2 + 8);
        scale = 2'd0;

        // pix_ce once every 4 clocks.
        $display("txn pix_ce every 4th clock");
        for (int i = 0; i < 600; i++) begin
            pix_ce = (i % 4 == 3);
            tick();
        end
        pix_ce = 1'b1;
        run(3);

        // Scan-line irq: set, hold, then ack.
        $display("txn irq set and ack");
        irq_line = 10'd2; irq_en = 1'b1;
        run_until(0, 2);
        spot(1, "irq", 1); spot(2, "irq", 1);
        run(2);
        irq_ack = 1'b1;
        spot(1, "irq", 0);
        tick();
        irq_ack = 1'b0;

        // Ack on the same edge as the set: set wins, the next ack clears.
        $display("txn irq set/ack same edge");
        run_until(0, 2);
        irq_ack = 1'b1;
        spot(1, "irq", 1); spot(2, "irq", 0);
        run(2);
        irq_ack = 1'b0;

        // Lowering irq_en leaves a pending irq in place.
        $display("txn irq_en drop keeps pending");
        run_until(0, 2);
        tick();
        irq_en = 1'b0;
        spot(20, "irq", 1);
        run(20);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // Disabled: the matching line produces nothing.
        $display("txn irq disabled");
        run_until(0, 2);
        spot(1, "irq", 0);
        run(5);

        // Out-of-range irq_line never fires.
        $display("txn irq_line out of range");
        irq_line = 10'd9; irq_en = 1'b1;
        spot(140, "irq", 0);
        run(140);

        // Reset mid-frame at (5,3) with an irq pending.
        $display("txn reset mid-frame");
        irq_line = 10'd3;
        run_until(0, 3);
        tick();
        run_until(5, 3);
        rst = 1'b1;
        spot(1, "irq", 0); spot(1, "posx", 0); spot(1, "posy", 0);
        spot(1, "hsync_o", 1); spot(1, "de_o", 0); spot(1, "line_start", 0);
        tick();
        rst = 1'b0;
        irq_en = 1'b0;
        spot(1, "frame_start", 1); spot(3, "de_o", 1);
        run(20);

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", seq_cnt, 32'(exp_q.size()), 32'd0);
        check("spots_consumed", seq_cnt, 32'(spot_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
